// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and its companions.
// Loader state encoding, default image length and the CPU opcode
// constants used by the control block and by testbenches.
package loader_pkg;

  typedef enum logic [2:0] {
    FILL,
    ARM,
    LOAD,
    RUN,
    ERR
  } state_e;

  localparam int unsigned PROG_BYTES_DEFAULT = 16;

  localparam logic [3:0] HLT = 4'h0;
  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] SUB = 4'h3;
  localparam logic [3:0] LDA = 4'h4;
  localparam logic [3:0] OUT = 4'h5;
  localparam logic [3:0] STA = 4'h6;
  localparam logic [3:0] JMP = 4'h7;

endpackage

// File: rtl/prog_buffer.sv
// Program image buffer: DEPTH x DATA_W register file with a
// synchronous write port and a combinational read port.
// Contents are deliberately not reset, so an image survives a reload.
module prog_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write one byte per accepted host transfer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Host-side program loader for the CPU programming handshake.
// Collects a PROG_BYTES image from a host over valid/ready, then holds
// the CPU in programming mode and feeds one byte per CPU load cycle,
// advancing on each rising edge of done_load. Releases programming after
// the last byte so the CPU runs from address 0; reload refills.
// Optional: define PROGRAM_LOADER_CHECKSUM_EN to accept a trailing
// two's-complement checksum byte and enter ERR on a mismatch.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned PROG_BYTES = PROG_BYTES_DEFAULT,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PTR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              reload,
  output logic              cpu_resetn,
  output logic              programming,
  output logic [DATA_W-1:0] prog_data,
  input  logic              read_ui_in,
  input  logic              done_load,
  input  logic              HF,
  output logic              loaded,
  output logic              halted,
  output logic              proto_err
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(PROG_BYTES - 1);

  state_e            state_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic              host_ready_q;
  logic              cpu_resetn_q;
  logic              programming_q;
  logic              loaded_q;
  logic              halted_q;
  logic              proto_err_q;
  logic              done_q;
  logic              read_seen_q;
  logic              done_edge;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              cks_phase_q;
`endif

  assign done_edge = done_load & ~done_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign buf_we = (state_q == FILL) && host_valid && host_ready_q && !reload && !cks_phase_q;
`else
  assign buf_we = (state_q == FILL) && host_valid && host_ready_q && !reload;
`endif

  prog_buffer #(
    .DEPTH (PROG_BYTES),
    .DATA_W(DATA_W),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk    (clk),
    .we_i   (buf_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(host_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(buf_rdata)
  );

  // Loader FSM with registered CPU-facing controls; reload overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      host_ready_q  <= 1'b1;
      cpu_resetn_q  <= 1'b0;
      programming_q <= 1'b0;
      loaded_q      <= 1'b0;
      halted_q      <= 1'b0;
      proto_err_q   <= 1'b0;
      done_q        <= 1'b0;
      read_seen_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q         <= '0;
      cks_phase_q   <= 1'b0;
`endif
    end else begin
      done_q <= done_load;
      if (reload) begin
        state_q       <= FILL;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        host_ready_q  <= 1'b1;
        cpu_resetn_q  <= 1'b0;
        programming_q <= 1'b0;
        loaded_q      <= 1'b0;
        halted_q      <= 1'b0;
        proto_err_q   <= 1'b0;
        read_seen_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_q         <= '0;
        cks_phase_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          FILL: begin
            if (host_valid && host_ready_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              // The extra byte after the image is the checksum, not stored.
              if (cks_phase_q) begin
                cks_phase_q  <= 1'b0;
                host_ready_q <= 1'b0;
                if ((sum_q + host_data) == '0) begin
                  state_q <= ARM;
                end else begin
                  state_q     <= ERR;
                  proto_err_q <= 1'b1;
                end
              end else begin
                sum_q <= sum_q + host_data;
                if (wr_ptr_q == LAST) begin
                  wr_ptr_q    <= '0;
                  cks_phase_q <= 1'b1;
                end else begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                end
              end
`else
              if (wr_ptr_q == LAST) begin
                wr_ptr_q     <= '0;
                host_ready_q <= 1'b0;
                state_q      <= ARM;
              end else begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
              end
`endif
            end
          end
          ARM: begin
            programming_q <= 1'b1;
            cpu_resetn_q  <= 1'b1;
            rd_ptr_q      <= '0;
            read_seen_q   <= 1'b0;
            state_q       <= LOAD;
          end
          LOAD: begin
            if (read_ui_in) begin
              read_seen_q <= 1'b1;
            end
            if (done_edge) begin
              // A read strobe in the same cycle as the edge still counts.
              if (!(read_seen_q || read_ui_in)) begin
                proto_err_q <= 1'b1;
              end
              read_seen_q <= 1'b0;
              if (rd_ptr_q == LAST) begin
                rd_ptr_q      <= '0;
                programming_q <= 1'b0;
                loaded_q      <= 1'b1;
                state_q       <= RUN;
              end else begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
              end
            end
          end
          RUN: begin
            halted_q <= HF;
          end
          default: begin
            // ERR holds the CPU in reset until reload or reset.
          end
        endcase
      end
    end
  end

  assign host_ready  = host_ready_q;
  assign cpu_resetn  = cpu_resetn_q;
  assign programming = programming_q;
  assign loaded      = loaded_q;
  assign halted      = halted_q;
  assign proto_err   = proto_err_q;
  assign prog_data   = (state_q == LOAD) ? buf_rdata : '0;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard testbench for program_loader. The driver plays host and CPU;
// every byte the CPU is expected to see is queued when its read strobe is
// issued and a monitor compares prog_data whenever the loader presents it.
module tb_program_loader;
  import loader_pkg::*;

  localparam int unsigned NB = PROG_BYTES_DEFAULT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] host_data = '0;
  logic       host_valid = 1'b0;
  logic       reload = 1'b0;
  logic       read_ui_in = 1'b0;
  logic       done_load = 1'b0;
  logic       HF = 1'b0;
  logic       host_ready, cpu_resetn, programming, loaded, halted, proto_err;
  logic [7:0] prog_data;

  always #5 clk = ~clk;

  program_loader #(
    .PROG_BYTES(NB),
    .DATA_W    (8),
    .PTR_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .reload     (reload),
    .cpu_resetn (cpu_resetn),
    .programming(programming),
    .prog_data  (prog_data),
    .read_ui_in (read_ui_in),
    .done_load  (done_load),
    .HF         (HF),
    .loaded     (loaded),
    .halted     (halted),
    .proto_err  (proto_err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_img[NB];
  logic       exp_proto = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] cks_adj = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: the loader presents a byte while programming with read_ui_in high.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (read_ui_in && programming) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL prog_data_unexpected: got 0x%0h with empty scoreboard", prog_data);
        end else begin
          e = exp_q.pop_front();
          chk("prog_data", prog_data, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_idle(input string tag);
    chk({tag, "_host_ready"}, host_ready, 1);
    chk({tag, "_cpu_resetn"}, cpu_resetn, 0);
    chk({tag, "_programming"}, programming, 0);
    chk({tag, "_prog_data"}, prog_data, 0);
    chk({tag, "_loaded"}, loaded, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  task automatic rand_img();
    for (int i = 0; i < NB; i++) cur_img[i] = 8'($urandom);
  endtask

  // Host sends the image with host_valid held high; extras must be ignored.
  task automatic fill();
    logic [7:0] sum;
    sum = '0;
    for (int k = 0; k < NB; k++) begin
      chk("fill_ready", host_ready, 1);
      chk("fill_resetn", cpu_resetn, 0);
      host_valid = 1'b1;
      host_data  = cur_img[k];
      sum        = sum + cur_img[k];
      tick();
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk("fill_ready_cks", host_ready, 1);
    host_data = (8'h00 - sum) + cks_adj;
    tick();
`endif
    host_data = 8'hA5;
  endtask

  task automatic expect_arm();
    chk("arm_ready", host_ready, 0);
    chk("arm_programming", programming, 0);
    chk("arm_resetn", cpu_resetn, 0);
    tick();
    chk("load_programming", programming, 1);
    chk("load_resetn", cpu_resetn, 1);
    chk("load_ready", host_ready, 0);
    host_valid = 1'b0;
  endtask

  // CPU model: read strobe, then done_load pulse, one idle cycle per byte.
  task automatic run_load(input int skip_idx, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      if (k != skip_idx) begin
        read_ui_in = 1'b1;
        exp_q.push_back(cur_img[k]);
      end
      tick();
      read_ui_in = 1'b0;
      done_load  = 1'b1;
      tick();
      done_load = 1'b0;
      if (k == skip_idx) exp_proto = 1'b1;
      chk("load_proto_err", proto_err, exp_proto);
      if (k == NB - 1) begin
        chk("end_programming", programming, 0);
        chk("end_loaded", loaded, 1);
        chk("end_prog_data", prog_data, 0);
        chk("end_resetn", cpu_resetn, 1);
      end else begin
        chk("mid_programming", programming, 1);
        chk("mid_loaded", loaded, 0);
      end
      tick();
    end
  endtask

  task automatic run_halt();
    chk("run_halted0", halted, 0);
    HF = 1'b1;
    host_valid = 1'b1;
    tick();
    chk("run_halted1", halted, 1);
    chk("run_ready", host_ready, 0);
    chk("run_loaded", loaded, 1);
    chk("run_proto_sticky", proto_err, exp_proto);
    HF = 1'b0;
    host_valid = 1'b0;
    tick();
    chk("run_halted_follow", halted, 0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    exp_proto = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    // Incrementing image, clean handshake.
    for (int i = 0; i < NB; i++) cur_img[i] = 8'(8'h40 + i);
    fill();
    expect_arm();
    run_load(-1, NB);
    run_halt();
    do_reload("reload_halted");

    // Small program image, one missing read strobe.
    rand_img();
    cur_img[0] = {LDA, 4'hE};
    cur_img[1] = {ADD, 4'hF};
    cur_img[2] = {OUT, 4'h0};
    cur_img[3] = {HLT, 4'h0};
    fill();
    expect_arm();
    run_load(5, NB);
    run_halt();
    do_reload("reload_proto");

    // Reload mid-fill drops the simultaneous byte and restarts at 0.
    rand_img();
    for (int k = 0; k < 7; k++) begin
      host_valid = 1'b1;
      host_data  = 8'($urandom);
      tick();
    end
    host_data = 8'hAA;
    do_reload("reload_fill");
    host_valid = 1'b0;
    fill();
    expect_arm();
    run_load(-1, NB);
    run_halt();
    do_reload("reload_after_fill");

    // Reset in the middle of loading.
    rand_img();
    fill();
    expect_arm();
    run_load(-1, 5);
    reset = 1'b1;
    tick();
    check_idle("midload_reset");
    reset = 1'b0;
    exp_proto = 1'b0;

    // Reload in the middle of loading, then random images.
    rand_img();
    fill();
    expect_arm();
    run_load(-1, 3);
    do_reload("reload_load");
    for (int r = 0; r < 3; r++) begin
      rand_img();
      fill();
      expect_arm();
      run_load(-1, NB);
      run_halt();
      do_reload("reload_rand");
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    for (int i = 0; i < NB; i++) cur_img[i] = 8'h01;
    cks_adj = 8'h00;
    fill();
    expect_arm();
    do_reload("reload_cks_ok");
    cks_adj = 8'h01;
    fill();
    host_valid = 1'b0;
    chk("err_proto", proto_err, 1);
    chk("err_ready", host_ready, 0);
    chk("err_resetn", cpu_resetn, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("err_resetn_held", cpu_resetn, 0);
    chk("err_programming", programming, 0);
    do_reload("reload_err");
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
